mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit_if.sv | 24 ++
 rtl/mul_div_unit.sv | 176 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Request/result bundle for mul_div_unit: operation request, operands and HI/LO results.
// Handshake: Start is a one-cycle request sampled on the rising edge; it is accepted only while Busy is low,
// and Done pulses once, for the cycle after the HI/LO write, for every accepted MULT/MULTU/DIV/DIVU.
interface mul_div_unit_if;
  logic        Start;
  logic [2:0]  MDUOp;
  logic [31:0] S1;
  logic [31:0] S2;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [1:0]  dbg_state;

  modport master (
    output Start, MDUOp, S1, S2,
    input  Busy, Done, HI, LO, dbg_state
  );

  modport slave (
    input  Start, MDUOp, S1, S2,
    output Busy, Done, HI, LO, dbg_state
  );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and MTHI/MTLO moves.
// Define MDU_DIV_EN to build DIV/DIVU; without it those opcodes are reserved and no divider exists.
module mul_div_unit #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input logic           clk,
  input logic           rst_n,
  mul_div_unit_if.slave mdu
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
`ifdef MDU_DIV_EN
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);
`endif

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        idle;
  logic        busy;
  logic        last;
  logic        start_mul;
  logic        start_div;
  logic        mul_signed;
  logic [63:0] prod;

  assign idle      = (state_q == ST_IDLE);
  assign busy      = !idle;
  assign last      = busy && (cnt_q == 4'd0);
  assign start_mul = idle && mdu.Start && ((mdu.MDUOp == OP_MULT) || (mdu.MDUOp == OP_MULTU));

`ifdef MDU_DIV_EN
  assign start_div = idle && mdu.Start && ((mdu.MDUOp == OP_DIV) || (mdu.MDUOp == OP_DIVU));
`else
  assign start_div = 1'b0;
`endif

  // Sign-extending to 64 bits lets one unsigned multiplier serve both MULT and MULTU.
  assign mul_signed = (op_q == OP_MULT);
  assign prod = {{32{mul_signed & a_q[31]}}, a_q} * {{32{mul_signed & b_q[31]}}, b_q};

`ifdef MDU_DIV_EN
  logic        div_signed;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b;
  logic [31:0] q_mag, r_mag;
  logic [31:0] quo, rem;

  // Divide magnitudes and fix signs afterwards: 0x80000000 / -1 then wraps to 0x80000000 naturally.
  assign div_signed = (op_q == OP_DIV);
  assign neg_a = div_signed & a_q[31];
  assign neg_b = div_signed & b_q[31];
  assign mag_a = neg_a ? (~a_q + 32'd1) : a_q;
  assign mag_b = neg_b ? (~b_q + 32'd1) : b_q;
  assign q_mag = mag_a / mag_b;
  assign r_mag = mag_a % mag_b;
  assign quo   = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
  assign rem   = neg_a ? (~r_mag + 32'd1) : r_mag;
`endif

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: the counter is loaded with N-1 so exactly N edges pass in MUL/DIV.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_mul) begin
          state_d = ST_MUL;
          cnt_d   = MUL_LOAD;
        end
`ifdef MDU_DIV_EN
        else if (start_div) begin
          state_d = ST_DIV;
          cnt_d   = DIV_LOAD;
        end
`endif
      end
      ST_MUL, ST_DIV: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Output/datapath logic: operand capture, moves, result commit and the Done pulse.
  always_comb begin
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = last;

    if (start_mul || start_div) begin
      op_d = mdu.MDUOp;
      a_d  = mdu.S1;
      b_d  = mdu.S2;
    end

    if (idle && mdu.Start && (mdu.MDUOp == OP_MTHI)) begin
      hi_d = mdu.S1;
    end
    if (idle && mdu.Start && (mdu.MDUOp == OP_MTLO)) begin
      lo_d = mdu.S1;
    end

    if (last && (state_q == ST_MUL)) begin
      hi_d = prod[63:32];
      lo_d = prod[31:0];
    end

`ifdef MDU_DIV_EN
    // A zero divisor still runs the full latency but leaves HI/LO untouched.
    if (last && (state_q == ST_DIV) && (b_q != 32'd0)) begin
      hi_d = rem;
      lo_d = quo;
    end
`endif
  end

  assign mdu.Busy      = busy;
  assign mdu.Done      = done_q;
  assign mdu.HI        = hi_q;
  assign mdu.LO        = lo_q;
  assign mdu.dbg_state = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus randomized operations against an arithmetic model.
module tb_mul_div_unit;

  localparam int MUL_CYCLES = 5;
  localparam int DIV_CYCLES = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mul_div_unit_if mdu ();

  mul_div_unit #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mdu  (mdu)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] mdl_hi   = 32'd0;
  logic [31:0] mdl_lo   = 32'd0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  // Immediate moves update the model at once; multi-cycle results are returned in res.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output logic [63:0] res);
    longint sa, sb, p;
`ifdef MDU_DIV_EN
    longint q, r;
`endif
    cyc = 0;
    res = {mdl_hi, mdl_lo};
    case (op)
      3'd0, 3'd1: begin
        sa  = (op == 3'd0) ? longint'($signed(a)) : longint'({32'd0, a});
        sb  = (op == 3'd0) ? longint'($signed(b)) : longint'({32'd0, b});
        p   = sa * sb;
        res = p;
        cyc = MUL_CYCLES;
      end
`ifdef MDU_DIV_EN
      3'd2, 3'd3: begin
        cyc = DIV_CYCLES;
        if (b != 32'd0) begin
          sa  = (op == 3'd2) ? longint'($signed(a)) : longint'({32'd0, a});
          sb  = (op == 3'd2) ? longint'($signed(b)) : longint'({32'd0, b});
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
`endif
      3'd4: mdl_hi = a;
      3'd5: mdl_lo = a;
      default: ;
    endcase
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; returns at the falling edge of the Done cycle
  // (or one cycle later for immediate/ignored ops) so the next op can start right there.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int noise);
    int          cyc;
    logic [63:0] res;
    logic [63:0] old;
    old = {mdl_hi, mdl_lo};
    model_op(op, a, b, cyc, res);
    mdu.Start = 1'b1;
    mdu.MDUOp = op;
    mdu.S1    = a;
    mdu.S2    = b;
    @(negedge clk);
    mdu.Start = 1'b0;
    mdu.S1    = $urandom;
    mdu.S2    = $urandom;
    if (cyc == 0) begin
      check("imm_busy", mdu.Busy, 1'b0);
      check("imm_done", mdu.Done, 1'b0);
      check("imm_hilo", {mdu.HI, mdu.LO}, {mdl_hi, mdl_lo});
    end else begin
      exp_q.push_back(res);
      for (int i = 1; i <= cyc; i++) begin
        check("busy_high", mdu.Busy, 1'b1);
        check("done_low", mdu.Done, 1'b0);
        check("hilo_hold", {mdu.HI, mdu.LO}, old);
        if (noise == 1) begin
          mdu.Start = 1'($urandom_range(0, 1));
          mdu.MDUOp = 3'($urandom_range(0, 7));
          mdu.S1    = $urandom;
          mdu.S2    = $urandom;
        end else if (noise == 2 && i == 2) begin
          mdu.Start = 1'b1;
          mdu.MDUOp = 3'd5;
          mdu.S1    = 32'h55;
        end
        @(negedge clk);
        mdu.Start = 1'b0;
      end
      check("end_busy", mdu.Busy, 1'b0);
      check("end_done", mdu.Done, 1'b1);
      {mdl_hi, mdl_lo} = exp_q.pop_front();
      check("result", {mdu.HI, mdu.LO}, {mdl_hi, mdl_lo});
    end
  endtask

  task automatic idle_cycle();
    mdu.Start = 1'b0;
    @(negedge clk);
    check("idle_busy", mdu.Busy, 1'b0);
    check("idle_done", mdu.Done, 1'b0);
    check("idle_hilo", {mdu.HI, mdu.LO}, {mdl_hi, mdl_lo});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    rst_n     = 1'b0;
    mdu.Start = 1'b0;
    mdu.MDUOp = 3'd0;
    mdu.S1    = 32'd0;
    mdu.S2    = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", mdu.Busy, 1'b0);
    check("rst_done", mdu.Done, 1'b0);
    check("rst_hi", mdu.HI, 32'd0);
    check("rst_lo", mdu.LO, 32'd0);
    rst_n = 1'b1;

    // First Start right at the first edge with reset released.
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 0);
    check("mult_hi", mdu.HI, 32'hFFFF_FFFF);
    check("mult_lo", mdu.LO, 32'hFFFF_FFFA);
    run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 0);
    check("multu_hi", mdu.HI, 32'h0000_0001);
    check("multu_lo", mdu.LO, 32'hFFFF_FFFE);

`ifdef MDU_DIV_EN
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_lo", mdu.LO, 32'hFFFF_FFFD);
    check("div_hi", mdu.HI, 32'hFFFF_FFFF);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf_lo", mdu.LO, 32'h8000_0000);
    check("div_ovf_hi", mdu.HI, 32'd0);
    run_op(3'd3, 32'd100, 32'd0, 0);
    check("divz_lo", mdu.LO, 32'h8000_0000);
    check("divz_hi", mdu.HI, 32'd0);
`else
    run_op(3'd2, 32'd100, 32'd7, 0);
    check("nodiv_hi", mdu.HI, 32'h0000_0001);
    check("nodiv_lo", mdu.LO, 32'hFFFF_FFFE);
    run_op(3'd3, 32'd100, 32'd7, 0);
`endif

    // MTLO during busy cycle 2 is dropped; MTHI in the Done cycle is taken.
    run_op(3'd0, 32'd6, 32'd7, 2);
    check("ign_hi", mdu.HI, 32'd0);
    check("ign_lo", mdu.LO, 32'd42);
    run_op(3'd4, 32'hAB, 32'd0, 0);
    check("mthi_hi", mdu.HI, 32'hAB);
    check("mthi_lo", mdu.LO, 32'd42);
    run_op(3'd6, 32'h1234, 32'h5678, 0);
    run_op(3'd7, 32'h1234, 32'h5678, 0);
    idle_cycle();

    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(op, a, b, 1);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    // Reset during busy cycle 4 aborts the operation.
    run_op(3'd4, 32'hDEAD_0001, 32'd0, 0);
    run_op(3'd5, 32'hBEEF_0002, 32'd0, 0);
    mdu.Start = 1'b1;
`ifdef MDU_DIV_EN
    mdu.MDUOp = 3'd3;
`else
    mdu.MDUOp = 3'd1;
`endif
    mdu.S1 = 32'd9;
    mdu.S2 = 32'd3;
    @(negedge clk);
    mdu.Start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_busy", mdu.Busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", mdu.Busy, 1'b0);
    check("abort_done", mdu.Done, 1'b0);
    check("abort_hilo", {mdu.HI, mdu.LO}, 64'd0);
    mdl_hi = 32'd0;
    mdl_lo = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DIV_CYCLES + 2) idle_cycle();

    run_op(3'd1, 32'd9, 32'd3, 0);
    check("post_rst_lo", mdu.LO, 32'd27);
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
